// File: rtl/demux1_to_2_fifo.sv
// demux1_to_2_fifo
//   Registered 1-to-2 demultiplexer. Each accepted word is steered by in_sel into one of
//   two independent FIFOs (A for sel 0, B for sel 1). Each FIFO is drained by its own
//   valid/ready channel, so the two consumers can stall independently.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_data/in_sel      word to route and its destination (0 -> A, 1 -> B)
//   in_valid/in_ready   producer handshake; ready = selected FIFO not full
//   a_data/a_valid      head of FIFO A, a_ready pops it
//   b_data/b_valid      head of FIFO B, b_ready pops it
//   a_count/b_count     occupancy of each FIFO (0..DEPTH)
module demux1_to_2_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 2,
   localparam int unsigned CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] a_data,
   output logic             a_valid,
   input  logic             a_ready,
   output logic [WIDTH-1:0] b_data,
   output logic             b_valid,
   input  logic             b_ready,
   output logic [CW-1:0]    a_count,
   output logic [CW-1:0]    b_count
);

   localparam int unsigned PW = $clog2(DEPTH);

   // Index 0 is FIFO A, index 1 is FIFO B.
   logic [WIDTH-1:0] r_mem  [2][DEPTH];
   logic [PW-1:0]    r_wptr [2];
   logic [PW-1:0]    r_rptr [2];
   logic [CW-1:0]    r_cnt  [2];

   logic w_full   [2];
   logic w_push   [2];
   logic w_pop    [2];
   logic w_oready [2];

   always_comb begin
      w_oready[0] = a_ready;
      w_oready[1] = b_ready;
      for (int d = 0; d < 2; d++) begin
         w_full[d] = (r_cnt[d] == CW'(DEPTH));
         // Pop only when the head is valid; ready on an empty FIFO is ignored.
         w_pop[d]  = (r_cnt[d] != '0) & w_oready[d];
      end
      // Readiness looks only at the selected FIFO's registered count, never at the
      // consumer's ready, so a full FIFO cannot be pushed even while it is popping.
      in_ready  = in_sel ? !w_full[1] : !w_full[0];
      w_push[0] = in_valid & in_ready & ~in_sel;
      w_push[1] = in_valid & in_ready & in_sel;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int d = 0; d < 2; d++) begin
            r_wptr[d] <= '0;
            r_rptr[d] <= '0;
            r_cnt[d]  <= '0;
            for (int e = 0; e < DEPTH; e++) begin
               r_mem[d][e] <= '0;
            end
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            if (w_push[d]) begin
               r_mem[d][r_wptr[d]] <= in_data;
               // DEPTH is a power of two, so natural overflow wraps the pointer.
               r_wptr[d] <= r_wptr[d] + PW'(1);
            end
            if (w_pop[d]) begin
               r_rptr[d] <= r_rptr[d] + PW'(1);
            end
            case ({w_push[d], w_pop[d]})
               2'b10:   r_cnt[d] <= r_cnt[d] + CW'(1);
               2'b01:   r_cnt[d] <= r_cnt[d] - CW'(1);
               default: r_cnt[d] <= r_cnt[d];
            endcase
         end
      end
   end

   // Heads come straight from storage; there is no bypass from in_data.
   assign a_data  = r_mem[0][r_rptr[0]];
   assign b_data  = r_mem[1][r_rptr[1]];
   assign a_valid = (r_cnt[0] != '0);
   assign b_valid = (r_cnt[1] != '0);
   assign a_count = r_cnt[0];
   assign b_count = r_cnt[1];

endmodule

// File: tb/tb_demux1_to_2_fifo.sv
// tb_demux1_to_2_fifo
//   Directed bench for demux1_to_2_fifo: reset, routing, backpressure, full-with-pop,
//   async reset mid-stream, ignored inputs and a scoreboarded streaming run with wrap.
module tb_demux1_to_2_fifo;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned CW    = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_sel = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a_data;
   logic             a_valid;
   logic             a_ready = 1'b0;
   logic [WIDTH-1:0] b_data;
   logic             b_valid;
   logic             b_ready = 1'b0;
   logic [CW-1:0]    a_count;
   logic [CW-1:0]    b_count;

   int n_cmp = 0;
   int n_bad = 0;

   demux1_to_2_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_sel   (in_sel),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a_data   (a_data),
      .a_valid  (a_valid),
      .a_ready  (a_ready),
      .b_data   (b_data),
      .b_valid  (b_valid),
      .b_ready  (b_ready),
      .a_count  (a_count),
      .b_count  (b_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] qa[$];
   logic [31:0] qb[$];

   initial begin
      int  idx;
      bit  exp_rdy;
      bit  pop_a;
      bit  pop_b;
      bit  done;

      // Reset then idle
      step();
      step();
      rst = 1'b0;
      #1;
      check("rst_a_valid", 32'(a_valid), 32'd0);
      check("rst_b_valid", 32'(b_valid), 32'd0);
      check("rst_a_count", 32'(a_count), 32'd0);
      check("rst_b_count", 32'(b_count), 32'd0);
      check("rst_a_data", a_data, 32'd0);
      in_sel = 1'b0;
      #1;
      check("rst_rdy_sel0", 32'(in_ready), 32'd1);
      in_sel = 1'b1;
      #1;
      check("rst_rdy_sel1", 32'(in_ready), 32'd1);

      // Routing with both consumers ready
      a_ready  = 1'b1;
      b_ready  = 1'b1;
      in_valid = 1'b1;
      in_sel   = 1'b0;
      in_data  = 32'h1111_1111;
      step();
      check("route_a_valid", 32'(a_valid), 32'd1);
      check("route_a_data", a_data, 32'h1111_1111);
      check("route_b_valid0", 32'(b_valid), 32'd0);
      check("route_a_count", 32'(a_count), 32'd1);
      in_sel  = 1'b1;
      in_data = 32'h2222_2222;
      step();
      check("route_a_drained", 32'(a_valid), 32'd0);
      check("route_b_valid", 32'(b_valid), 32'd1);
      check("route_b_data", b_data, 32'h2222_2222);
      check("route_b_count", 32'(b_count), 32'd1);
      in_valid = 1'b0;
      step();
      check("route_b_drained", 32'(b_valid), 32'd0);

      // Fill A and backpressure
      a_ready  = 1'b0;
      b_ready  = 1'b0;
      in_valid = 1'b1;
      in_sel   = 1'b0;
      in_data  = 32'hA0;
      step();
      in_data = 32'hA1;
      step();
      check("fill_a_count", 32'(a_count), 32'd2);
      check("fill_rdy_sel0", 32'(in_ready), 32'd0);
      in_sel  = 1'b1;
      in_data = 32'hB0;
      #1;
      check("fill_rdy_sel1", 32'(in_ready), 32'd1);
      step();
      check("fill_b_count", 32'(b_count), 32'd1);
      check("fill_b_data", b_data, 32'hB0);
      check("fill_a_count_hold", 32'(a_count), 32'd2);
      in_valid = 1'b0;
      check("fill_a_head0", a_data, 32'hA0);
      a_ready = 1'b1;
      b_ready = 1'b1;
      step();
      check("fill_a_head1", a_data, 32'hA1);
      check("fill_a_count1", 32'(a_count), 32'd1);
      check("fill_b_count0", 32'(b_count), 32'd0);
      step();
      check("fill_a_empty", 32'(a_valid), 32'd0);

      // Full with simultaneous pop
      a_ready  = 1'b0;
      in_valid = 1'b1;
      in_sel   = 1'b0;
      in_data  = 32'hC0;
      step();
      in_data = 32'hC1;
      step();
      check("fp_count2", 32'(a_count), 32'd2);
      a_ready = 1'b1;
      in_data = 32'hC2;
      #1;
      check("fp_rdy_full", 32'(in_ready), 32'd0);
      step();
      check("fp_count1", 32'(a_count), 32'd1);
      check("fp_head_c1", a_data, 32'hC1);
      check("fp_rdy_again", 32'(in_ready), 32'd1);
      step();
      check("fp_pushpop_count", 32'(a_count), 32'd1);
      check("fp_head_c2", a_data, 32'hC2);
      in_valid = 1'b0;
      step();
      check("fp_empty", 32'(a_count), 32'd0);

      // Async reset mid-stream with A holding two words
      a_ready  = 1'b0;
      in_valid = 1'b1;
      in_sel   = 1'b0;
      in_data  = 32'hD0;
      step();
      in_data = 32'hD1;
      step();
      in_valid = 1'b0;
      check("ar_count2", 32'(a_count), 32'd2);
      #2;
      rst = 1'b1;
      #1;
      check("ar_count0", 32'(a_count), 32'd0);
      check("ar_valid0", 32'(a_valid), 32'd0);
      check("ar_data0", a_data, 32'd0);
      step();
      rst = 1'b0;
      #1;
      check("ar_rdy_after", 32'(in_ready), 32'd1);

      // Ignored inputs: no valid, consumers ready on empty FIFOs
      a_ready = 1'b1;
      b_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_sel  = i[0];
         in_data = 32'hDEAD_0000 + 32'(i);
         step();
         check("ign_a_count", 32'(a_count), 32'd0);
         check("ign_b_count", 32'(b_count), 32'd0);
         check("ign_a_data", a_data, 32'd0);
         check("ign_b_data", b_data, 32'd0);
      end
      // Pointers untouched: next push to B lands in slot 0 and is the head.
      b_ready  = 1'b0;
      in_valid = 1'b1;
      in_sel   = 1'b1;
      in_data  = 32'hE0;
      step();
      in_valid = 1'b0;
      check("ign_b_head", b_data, 32'hE0);
      check("ign_b_count1", 32'(b_count), 32'd1);
      b_ready = 1'b1;
      step();
      check("ign_b_drain", 32'(b_count), 32'd0);

      // Streaming with random consumer stalls and a per-destination scoreboard
      idx  = 0;
      done = 1'b0;
      for (int cyc = 0; cyc < 200; cyc++) begin
         if (idx >= 10 && qa.size() == 0 && qb.size() == 0) begin
            done = 1'b1;
            break;
         end
         in_valid = (idx < 10);
         in_sel   = idx[0];
         in_data  = 32'hC000_0000 + 32'(idx);
         a_ready  = 1'($urandom_range(1, 0));
         b_ready  = 1'($urandom_range(1, 0));
         #1;
         check("st_a_valid", 32'(a_valid), 32'(qa.size() != 0));
         check("st_b_valid", 32'(b_valid), 32'(qb.size() != 0));
         check("st_a_count", 32'(a_count), 32'(qa.size()));
         check("st_b_count", 32'(b_count), 32'(qb.size()));
         if (qa.size() != 0) check("st_a_data", a_data, qa[0]);
         if (qb.size() != 0) check("st_b_data", b_data, qb[0]);
         exp_rdy = in_sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
         check("st_in_ready", 32'(in_ready), 32'(exp_rdy));
         pop_a = (qa.size() != 0) && a_ready;
         pop_b = (qb.size() != 0) && b_ready;
         if (pop_a) void'(qa.pop_front());
         if (pop_b) void'(qb.pop_front());
         if (in_valid && exp_rdy) begin
            if (in_sel) qb.push_back(in_data);
            else        qa.push_back(in_data);
            idx++;
         end
         step();
      end
      check("st_completed", 32'(done), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
